// File: rtl/ysyx_22040632_div_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_div_pkg
// Shared types and widths for the iterative radix-2 divider.
//   div_state_t : divider FSM states (IDLE, CALC, DONE)
//   XLEN        : operand / result width of the RV64 datapath
//   WORD_W      : width of the *W (32-bit word) operations
//   CNT_W       : width of the per-bit iteration counter (counts XLEN-1..0)
// ---------------------------------------------------------------------------
package ysyx_22040632_div_pkg;

  localparam int XLEN   = 64;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/ysyx_22040632_div_prep.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_div_prep
// Combinational operand preparation for the divider.
//   div_signed, divw     : operation kind (signed / 32-bit word)
//   dividend, divisor    : raw operands from the EXU
//   abs_dividend/divisor : magnitudes of the effective operands
//   neg_q, neg_r         : result sign corrections to apply after the loop
//   special              : divide-by-zero or signed overflow; result is known
//   special_quotient/remainder : the known result (already word-extended)
// ---------------------------------------------------------------------------
module ysyx_22040632_div_prep
  import ysyx_22040632_div_pkg::WORD_W;
#(
  parameter int XLEN = 64
) (
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] abs_dividend,
  output logic [XLEN-1:0] abs_divisor,
  output logic            neg_q,
  output logic            neg_r,
  output logic            special,
  output logic [XLEN-1:0] special_quotient,
  output logic [XLEN-1:0] special_remainder
);

  localparam int HI_W = XLEN - WORD_W;

  logic [XLEN-1:0] eff_dividend;
  logic [XLEN-1:0] eff_divisor;
  logic [XLEN-1:0] dividend_sext;
  logic [XLEN-1:0] most_neg;
  logic            sign_dd;
  logic            sign_ds;
  logic            div_zero;
  logic            overflow;

  always_comb begin
    dividend_sext = {{HI_W{dividend[WORD_W-1]}}, dividend[WORD_W-1:0]};

    // Word ops work on the low half, widened the way the op interprets it,
    // so the rest of the datapath only ever sees full-width values.
    if (divw) begin
      eff_dividend = div_signed ? dividend_sext
                                : {{HI_W{1'b0}}, dividend[WORD_W-1:0]};
      eff_divisor  = div_signed ? {{HI_W{divisor[WORD_W-1]}}, divisor[WORD_W-1:0]}
                                : {{HI_W{1'b0}}, divisor[WORD_W-1:0]};
      most_neg     = {{(HI_W + 1){1'b1}}, {(WORD_W - 1){1'b0}}};
    end else begin
      eff_dividend = dividend;
      eff_divisor  = divisor;
      most_neg     = {1'b1, {(XLEN - 1){1'b0}}};
    end

    sign_dd = div_signed & eff_dividend[XLEN-1];
    sign_ds = div_signed & eff_divisor[XLEN-1];

    // The magnitude of the most-negative value is still representable as an
    // unsigned XLEN-bit number, so no extra bit is needed here.
    abs_dividend = sign_dd ? -eff_dividend : eff_dividend;
    abs_divisor  = sign_ds ? -eff_divisor  : eff_divisor;

    neg_q = sign_dd ^ sign_ds;
    neg_r = sign_dd;

    div_zero = (eff_divisor == '0);
    overflow = div_signed & (eff_divisor == '1) & (eff_dividend == most_neg);
    special  = div_zero | overflow;

    // Divide by zero: all-ones quotient, remainder is the dividend.
    // Overflow: quotient is the most-negative value, remainder zero.
    special_quotient  = div_zero ? '1 : most_neg;
    special_remainder = div_zero ? (divw ? dividend_sext : dividend) : '0;
  end

endmodule

// File: rtl/ysyx_22040632_divider.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_divider
// Iterative shift-subtract divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; results are held until the consumer takes them.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : abort any operation, return to IDLE next edge
//   div_valid / div_ready : request handshake (ready only in IDLE)
//   div_signed, divw      : signed op / 32-bit word op
//   dividend, divisor     : operands
//   out_valid / out_ready : result handshake
//   quotient, remainder   : registered results
// ---------------------------------------------------------------------------
module ysyx_22040632_divider
  import ysyx_22040632_div_pkg::div_state_t,
         ysyx_22040632_div_pkg::IDLE,
         ysyx_22040632_div_pkg::CALC,
         ysyx_22040632_div_pkg::DONE,
         ysyx_22040632_div_pkg::WORD_W,
         ysyx_22040632_div_pkg::CNT_W;
#(
  parameter int XLEN = ysyx_22040632_div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0] q_reg, q_next;        // dividend bits shifting out, quotient bits in
  logic [XLEN-1:0] rem_reg, rem_next;    // running remainder, always < |divisor|
  logic [XLEN-1:0] dvs_reg, dvs_next;    // |divisor|
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;
  logic            word_reg, word_next;
  logic [XLEN-1:0] quotient_reg, quotient_next;
  logic [XLEN-1:0] remainder_reg, remainder_next;
  logic            out_valid_reg, out_valid_next;

  logic [XLEN-1:0] p_abs_dividend;
  logic [XLEN-1:0] p_abs_divisor;
  logic            p_neg_q;
  logic            p_neg_r;
  logic            p_special;
  logic [XLEN-1:0] p_spec_q;
  logic [XLEN-1:0] p_spec_r;

  ysyx_22040632_div_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .div_signed        (div_signed),
    .divw              (divw),
    .dividend          (dividend),
    .divisor           (divisor),
    .abs_dividend      (p_abs_dividend),
    .abs_divisor       (p_abs_divisor),
    .neg_q             (p_neg_q),
    .neg_r             (p_neg_r),
    .special           (p_special),
    .special_quotient  (p_spec_q),
    .special_remainder (p_spec_r)
  );

  // ---- one shift-subtract step -------------------------------------------
  logic [XLEN:0]   partial;   // XLEN+1-bit working remainder
  logic            ge;
  logic [XLEN-1:0] diff_lo;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_q;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;

  always_comb begin
    partial  = {rem_reg, q_reg[XLEN-1]};
    ge       = (partial >= {1'b0, dvs_reg});
    // When ge holds the true difference is below |divisor|, so the low
    // XLEN bits of the subtraction are exact.
    diff_lo  = partial[XLEN-1:0] - dvs_reg;
    step_rem = ge ? diff_lo : partial[XLEN-1:0];
    step_q   = {q_reg[XLEN-2:0], ge};

    fix_q = neg_q_reg ? -step_q   : step_q;
    fix_r = neg_r_reg ? -step_rem : step_rem;
    if (word_reg) begin
      fix_q = {{(XLEN - WORD_W){fix_q[WORD_W-1]}}, fix_q[WORD_W-1:0]};
      fix_r = {{(XLEN - WORD_W){fix_r[WORD_W-1]}}, fix_r[WORD_W-1:0]};
    end
  end

  // ---- next-state / datapath ---------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    q_next         = q_reg;
    rem_next       = rem_reg;
    dvs_next       = dvs_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    word_next      = word_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (div_valid) begin
          neg_q_next = p_neg_q;
          neg_r_next = p_neg_r;
          word_next  = divw;
          dvs_next   = p_abs_divisor;
          rem_next   = '0;
          // Word magnitudes fit in the low half; park them at the top so the
          // loop always consumes dividend bits from the MSB.
          q_next     = divw ? (p_abs_dividend << (XLEN - WORD_W)) : p_abs_dividend;
          if (p_special) begin
            quotient_next  = p_spec_q;
            remainder_next = p_spec_r;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else begin
            cnt_next   = divw ? CNT_W'(WORD_W - 1) : CNT_W'(XLEN - 1);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        rem_next = step_rem;
        q_next   = step_q;
        if (cnt_reg == '0) begin
          quotient_next  = fix_q;
          remainder_next = fix_r;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase

    // Redirect wins over everything, including an accept in the same cycle;
    // the visible result registers keep their previous contents.
    if (flush) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      word_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      q_reg         <= q_next;
      rem_reg       <= rem_next;
      dvs_reg       <= dvs_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      word_reg      <= word_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign div_ready = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040632_divider
// Scoreboard bench: the driver pushes the expected result of every accepted
// request; a negedge monitor pops and compares when out_valid rises, and
// also checks hold-while-stalled and return-to-idle behaviour.
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_signed = 1'b0;
  logic        divw = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     valid_rises = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    longint      acc;
    int          hold;
  } exp_t;

  exp_t sb[$];

  ysyx_22040632_divider #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .divw       (divw),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endfunction

  // Reference: RISC-V M-extension division semantics in plain arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic spec);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    q32 = '0;
    r32 = '0;
    q = '0;
    r = '0;
    spec = 1'b0;
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; spec = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = 32'h8000_0000; r32 = '0; spec = 1'b1;
      end else if (s) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; spec = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = '0; spec = 1'b1;
      end else if (s) begin
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // ---- monitor / consumer ---------------------------------------------------
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_flush = 1'b0;
  logic [63:0] prev_q = '0;
  logic [63:0] prev_r = '0;
  int          cur_hold = 0;
  int          wait_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_flush = 1'b0;
      out_ready  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !prev_flush) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_quotient_stable", quotient, prev_q);
        check("stall_remainder_stable", remainder, prev_r);
      end
      if (prev_valid && prev_ready && !prev_flush) begin
        check("release_valid_low", 64'(out_valid), 64'd0);
        check("release_ready_high", 64'(div_ready), 64'd1);
      end
      if (out_valid)
        check("ready_low_while_valid", 64'(div_ready), 64'd0);
      if (out_valid && !prev_valid) begin
        valid_rises++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out_valid=1 q=%h r=%h, expected no result", quotient, remainder);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
          $display("result q=%h r=%h latency=%0d", quotient, remainder, cyc - e.acc + 1);
          cur_hold = e.hold;
          wait_cnt = 0;
        end
      end
      if (out_valid) begin
        if (wait_cnt < cur_hold) begin
          out_ready = 1'b0;
          wait_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_flush = flush;
      prev_q     = quotient;
      prev_r     = remainder;
    end
  end

  // ---- driver ---------------------------------------------------------------
  // Called in the slot just after a rising edge; returns in the same slot.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic push,
                       input logic have_exp, input logic [63:0] eq,
                       input logic [63:0] er, input int hold);
    int t;
    exp_t e;
    logic [63:0] mq, mr;
    logic spec;
    t = 0;
    while (!div_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!div_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got div_ready=0 after %0d cycles, expected 1", t);
      return;
    end
    dividend   = a;
    divisor    = b;
    div_signed = s;
    divw       = w;
    div_valid  = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    $display("issue a=%h b=%h signed=%0d word=%0d", a, b, s, w);
    if (push) begin
      ref_div(a, b, s, w, mq, mr, spec);
      e.q    = have_exp ? eq : mq;
      e.r    = have_exp ? er : mr;
      e.lat  = spec ? 1 : (w ? 33 : 65);
      e.acc  = cyc;
      e.hold = hold;
      sb.push_back(e);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish within time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    logic [63:0] a, b;
    logic s, w;
    int mode;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_div_ready", 64'(div_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_quotient", quotient, 64'd0);
    check("reset_remainder", remainder, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 1'b1, 64'd14, 64'd2, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1,
          64'h8000_0000_0000_0000, 64'd0, 2);
    // Word op with 5 cycles of backpressure
    do_op(64'h0000_0001_8000_0000, 64'd1, 1'b1, 1'b1, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 5);
    do_op(64'h1234_5678_8000_0001, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0);
    do_op(64'h0000_0000_8000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 0);

    // Flush 10 cycles into CALC, with a request offered in the flush cycle
    do_op(64'hDEAD_BEEF_0000_1234, 64'd77, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0);
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    div_valid = 1'b1;
    dividend  = 64'd50;
    divisor   = 64'd5;
    @(posedge clk); #1;
    flush     = 1'b0;
    div_valid = 1'b0;
    check("flush_div_ready", 64'(div_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    base = valid_rises;
    repeat (80) @(posedge clk);
    #1;
    check("flush_no_result", 64'(valid_rises), 64'(base));
    do_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b1, 1'b1, 64'd3, 64'd0, 0);

    // Asynchronous reset in the middle of CALC
    do_op(64'hFFFF_0000_FFFF_0000, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_div_ready", 64'(div_ready), 64'd1);
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_quotient", quotient, 64'd0);
    check("async_reset_remainder", remainder, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        b = w ? {b[63:32], 32'd0} : 64'd0;
      end else if (mode == 1) begin
        s = 1'b1;
        if (w) begin
          a = {a[63:32], 32'h8000_0000};
          b = {b[63:32], 32'hFFFF_FFFF};
        end else begin
          a = 64'h8000_0000_0000_0000;
          b = 64'hFFFF_FFFF_FFFF_FFFF;
        end
      end else if (mode < 5) begin
        b = b >> $urandom_range(32, 63);
      end else if (mode < 7) begin
        a = a >> $urandom_range(0, 40);
      end
      do_op(a, b, s, w, 1'b1, 1'b0, '0, '0, $urandom_range(0, 3));
    end

    t = 0;
    while ((sb.size() != 0 || !div_ready) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("final_idle", 64'(div_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
